// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer for the UART receiver.
// It converts the receiver's level-style rx_done flag into one write per frame.
// Bytes go into a circular FIFO, and the host side reads them through a
// first-word fall-through valid/ready stream.
// When a byte arrives while the FIFO is full, the byte is dropped, a sticky
// overflow flag is set, and a saturating drop counter is incremented.
// If rx_done is still high when reset releases, one spurious write occurs.
// Do not release reset while a frame is completing.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        drop_count,
  input  logic              ovf_clear
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              rx_done_q, rx_done_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_count_q, drop_count_d;

  logic wr_req, wr_en, pop, drop;

  // Status flags and stream outputs come only from registered state.
  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == (ADDR_W+1)'(DEPTH));
    m_valid = ~empty;
    m_data  = mem[rd_ptr_q];
    level   = level_q;
    overflow   = overflow_q;
    drop_count = drop_count_q;
  end

  // Edge detect, write acceptance, and next-state for pointers, level and overflow.
  always_comb begin
    rx_done_d = rx_done;
    wr_req    = rx_done & ~rx_done_q;
    pop       = m_valid & m_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept the write.
    wr_en     = wr_req & (~full | pop);
    drop      = wr_req & full & ~pop;

    rd_ptr_d = pop   ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;

    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + (ADDR_W+1)'(1);
    else if (pop && !wr_en) level_d = level_q - (ADDR_W+1)'(1);

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      // A drop takes priority over a clear in the same cycle, so the dropped byte is still counted.
      overflow_d = 1'b1;
      if (ovf_clear)                  drop_count_d = 8'd1;
      else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end else if (ovf_clear) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      rx_done_q    <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      rx_done_q    <= rx_done_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage array; it is not reset, because contents past rd_ptr are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo. It uses a byte scoreboard queue.
// Inputs are driven and outputs sampled on the falling edge.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] drop_count;
  logic       ovf_clear;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb [$];
  logic [7:0] last_rd;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .full(full), .empty(empty), .overflow(overflow), .drop_count(drop_count),
    .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rx_done pulse; this task returns on the falling edge after the write has committed.
  task automatic push(input logic [7:0] d, input bit expect_store);
    @(negedge clk);
    rx_data = d;
    rx_done = 1'b1;
    if (expect_store) sb.push_back(d);
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Pop one byte and compare it against the scoreboard head.
  task automatic pop_one(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, m_valid, 1'b1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      last_rd = sb.pop_front();
      chk({tag, "_data"}, m_data, last_rd);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; m_ready = 1'b0; ovf_clear = 1'b0;

    // 1. Reset values
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_level", level, 5'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drops", drop_count, 8'd0);

    // 2. Single byte, rx_done held high for 50 cycles
    rx_data = 8'hA5; rx_done = 1'b1;
    sb.push_back(8'hA5);
    @(negedge clk);
    chk("single_valid_lat", m_valid, 1'b1);
    chk("single_data", m_data, 8'hA5);
    chk("single_level_lat", level, 5'd1);
    repeat (49) @(negedge clk);
    chk("single_level_held", level, 5'd1);
    rx_done = 1'b0;
    pop_one("single_pop");
    chk("single_level_after", level, 5'd0);
    chk("single_valid_after", m_valid, 1'b0);

    // 3. Fill, then overflow, then drain in order
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("fill_full", full, 1'b1);
    chk("fill_level", level, 5'd16);
    push(8'hFF, 1'b0);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_drops", drop_count, 8'd1);
    chk("ovf_level", level, 5'd16);
    for (int i = 0; i < 16; i++) pop_one("drain3");
    chk("drain3_empty", empty, 1'b1);

    // 4. Push and pop together while full
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    @(negedge clk);
    chk("fullpp_head", m_data, sb[0]);
    void'(sb.pop_front());
    sb.push_back(8'h55);
    rx_data = 8'h55; rx_done = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; m_ready = 1'b0;
    chk("fullpp_level", level, 5'd16);
    chk("fullpp_ovf", overflow, 1'b1);
    chk("fullpp_drops", drop_count, 8'd1);
    for (int i = 0; i < 16; i++) pop_one("drain4");
    chk("drain4_last", last_rd, 8'h55);
    chk("drain4_empty", empty, 1'b1);

    // 5. Pointer wrap, drop-counter saturation, and a clear that coincides with a drop
    for (int i = 0; i < 40; i++) begin
      push(8'h40 + 8'(i), 1'b1);
      pop_one("wrap");
    end
    for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i), 1'b1);
    for (int i = 0; i < 300; i++) push(8'hEE, 1'b0);
    chk("sat_drops", drop_count, 8'd255);
    chk("sat_ovf", overflow, 1'b1);
    @(negedge clk);
    rx_data = 8'hEE; rx_done = 1'b1; ovf_clear = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; ovf_clear = 1'b0;
    chk("clrset_ovf", overflow, 1'b1);
    chk("clrset_drops", drop_count, 8'd1);
    ovf_clear = 1'b1;
    @(negedge clk);
    ovf_clear = 1'b0;
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_drops", drop_count, 8'd0);
    for (int i = 0; i < 16; i++) pop_one("drain5");
    chk("drain5_empty", empty, 1'b1);

    // 6. Reset in the middle of operation
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1'b1);
    chk("mid_level", level, 5'd5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_level", level, 5'd0);
    chk("mid_rst_valid", m_valid, 1'b0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    push(8'h3C, 1'b1);
    push(8'h77, 1'b1);
    pop_one("post_rst");
    chk("post_rst_first", last_rd, 8'h3C);
    pop_one("post_rst");
    chk("post_rst_empty", empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
